// File: rtl/pixel_color_scheduler.sv
// rtl/pixel_color_scheduler.sv - round-robin colour-LUT read scheduler for Mandelbrot engines
module pixel_color_scheduler #(
    parameter int DATA_WIDTH    = 32,
    parameter int RBG_SIZE      = 24,
    parameter int MAX_ITERATION = 50,
    parameter int NUM_ENGINES   = 30,
    parameter int ID_WIDTH      = $clog2(NUM_ENGINES),
    parameter int ADDR_WIDTH    = $clog2(MAX_ITERATION),
    parameter int OUT_DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_ENGINES-1:0] eng_req,
    input  logic [DATA_WIDTH-1:0]  eng_iter [NUM_ENGINES],
    output logic [NUM_ENGINES-1:0] eng_ack,
    output logic                   lut_rd_en,
    output logic [ADDR_WIDTH-1:0]  lut_addr,
    input  logic [RBG_SIZE-1:0]    lut_rgb,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [RBG_SIZE-1:0]    pix_rgb,
    output logic [ID_WIDTH-1:0]    pix_engine,
    output logic                   pix_in_set,
    output logic                   busy
);

    localparam int PTR_W   = $clog2(OUT_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = RBG_SIZE + ID_WIDTH + 1;

    localparam logic [DATA_WIDTH-1:0] LAST_ITER = DATA_WIDTH'(MAX_ITERATION - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAX_ITERATION - 1);
    localparam logic [ID_WIDTH-1:0]   LAST_ID   = ID_WIDTH'(NUM_ENGINES - 1);

    // arbitration state
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic                  grant_vld;
    logic [ID_WIDTH-1:0]   grant_id;
    logic                  credit;

    // clamp of the granted count
    logic [DATA_WIDTH-1:0] sel_iter;
    logic                  in_set_d;
    logic [ADDR_WIDTH-1:0] addr_d;

    // LUT read pipeline: s1 = read issued, s2 = LUT data on lut_rgb
    logic                  s1_valid_q;
    logic [ID_WIDTH-1:0]   s1_id_q;
    logic                  s1_in_set_q;
    logic [ADDR_WIDTH-1:0] lut_addr_q;
    logic                  s2_valid_q;
    logic [ID_WIDTH-1:0]   s2_id_q;
    logic                  s2_in_set_q;

    // output FIFO
    logic [ENTRY_W-1:0]    fifo_mem_q [OUT_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      fifo_count_q, fifo_count_d;
    logic                  push;
    logic                  pop;
    logic [RBG_SIZE-1:0]   head_rgb;
    logic [ID_WIDTH-1:0]   head_id;
    logic                  head_in_set;

    // Credit counts only registered occupancy, so a same-cycle pop never frees a slot early.
    always_comb begin
        credit = (int'(fifo_count_q) + int'(s1_valid_q) + int'(s2_valid_q)) < OUT_DEPTH;
    end

    // Round-robin search starting at rr_ptr, wrapping past the last engine.
    always_comb begin : arb_search
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_ENGINES) begin
                idx = idx - NUM_ENGINES;
            end
            if (!grant_vld && eng_req[idx]) begin
                grant_vld = 1'b1;
                grant_id  = ID_WIDTH'(idx);
            end
        end
        if (!(rst_n && credit)) begin
            grant_vld = 1'b0;
            grant_id  = '0;
        end
    end

    // One-hot acknowledge and next round-robin pointer.
    always_comb begin
        eng_ack = '0;
        if (grant_vld) begin
            eng_ack[grant_id] = 1'b1;
        end
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (grant_id == LAST_ID) ? '0 : grant_id + ID_WIDTH'(1);
        end
    end

    // Clamp at full width so huge counts do not alias onto low LUT entries.
    always_comb begin
        sel_iter = eng_iter[grant_id];
        in_set_d = (sel_iter >= LAST_ITER);
        addr_d   = in_set_d ? LAST_ADDR : sel_iter[ADDR_WIDTH-1:0];
    end

    // Arbiter pointer and the two LUT pipeline stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s1_in_set_q <= 1'b0;
            lut_addr_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_id_q     <= '0;
            s2_in_set_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            s1_valid_q <= grant_vld;
            if (grant_vld) begin
                s1_id_q     <= grant_id;
                s1_in_set_q <= in_set_d;
                lut_addr_q  <= addr_d;
            end
            s2_valid_q  <= s1_valid_q;
            s2_id_q     <= s1_id_q;
            s2_in_set_q <= s1_in_set_q;
        end
    end

    assign lut_rd_en = s1_valid_q;
    assign lut_addr  = lut_addr_q;

    // FIFO control: push LUT data with its tag, pop on downstream handshake.
    always_comb begin
        push         = s2_valid_q;
        pop          = pix_valid && pix_ready;
        wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        fifo_count_d = fifo_count_q;
        if (push && !pop) begin
            fifo_count_d = fifo_count_q + CNT_W'(1);
        end else if (!push && pop) begin
            fifo_count_d = fifo_count_q - CNT_W'(1);
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {lut_rgb, s2_id_q, s2_in_set_q};
        end
    end

    assign {head_rgb, head_id, head_in_set} = fifo_mem_q[rd_ptr_q];

    // Output stream shows the FIFO head, forced to zero while empty.
    always_comb begin
        pix_valid  = (fifo_count_q != '0);
        pix_rgb    = pix_valid ? head_rgb : '0;
        pix_engine = pix_valid ? head_id : '0;
        pix_in_set = pix_valid ? head_in_set : 1'b0;
        busy       = s1_valid_q | s2_valid_q | (fifo_count_q != '0);
    end

endmodule

// File: tb/tb_pixel_color_scheduler.sv
// tb/tb_pixel_color_scheduler.sv - scoreboard bench for pixel_color_scheduler
module tb_pixel_color_scheduler;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int RW    = 24;
    localparam int MAXI  = 50;
    localparam int AW    = 6;
    localparam int IW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  eng_req;
    logic [DW-1:0] eng_iter [N];
    logic [N-1:0]  eng_ack;
    logic          lut_rd_en;
    logic [AW-1:0] lut_addr;
    logic [RW-1:0] lut_rgb;
    logic          pix_valid;
    logic          pix_ready;
    logic [RW-1:0] pix_rgb;
    logic [IW-1:0] pix_engine;
    logic          pix_in_set;
    logic          busy;

    always #5 clk = ~clk;

    pixel_color_scheduler #(
        .DATA_WIDTH(DW), .RBG_SIZE(RW), .MAX_ITERATION(MAXI),
        .NUM_ENGINES(N), .OUT_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .eng_req(eng_req), .eng_iter(eng_iter), .eng_ack(eng_ack),
        .lut_rd_en(lut_rd_en), .lut_addr(lut_addr), .lut_rgb(lut_rgb),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_rgb(pix_rgb),
        .pix_engine(pix_engine), .pix_in_set(pix_in_set), .busy(busy)
    );

    // synchronous colour LUT: data one cycle after the read strobe
    logic [RW-1:0] lut_mem [64];
    always @(posedge clk) if (lut_rd_en) lut_rgb <= lut_mem[lut_addr];

    typedef struct {
        int          eng;
        logic [RW-1:0] rgb;
        bit          in_set;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   failures = 0;

    // reference model state
    int rr_m = 0;
    int outstanding = 0;
    bit prev_vld = 0;
    int prev_addr = 0;
    bit last_pv = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int exp_addr(input logic [DW-1:0] it);
        return (it >= MAXI - 1) ? MAXI - 1 : int'(it);
    endfunction

    function automatic logic [DW-1:0] rand_iter();
        case ($urandom % 4)
            0:       return DW'($urandom_range(0, 48));
            1:       return DW'($urandom_range(49, 50));
            2:       return $urandom;
            default: return DW'($urandom_range(0, 63));
        endcase
    endfunction

    // Sample one cycle at the falling edge and compare against the model.
    task automatic sample_cycle(output int g);
        exp_t e;
        int   a;
        @(negedge clk);
        last_pv = pix_valid;
        check("lut_rd_en", lut_rd_en, prev_vld);
        if (prev_vld) check("lut_addr", lut_addr, prev_addr);
        g = -1;
        if (outstanding < DEPTH) begin
            for (int i = 0; i < N; i++) begin
                int idx;
                idx = (rr_m + i) % N;
                if (g < 0 && eng_req[idx]) g = idx;
            end
        end
        check("eng_ack", eng_ack, (g < 0) ? 64'd0 : (64'd1 << g));
        prev_vld = (g >= 0);
        if (g >= 0) begin
            a        = exp_addr(eng_iter[g]);
            e.eng    = g;
            e.rgb    = lut_mem[a];
            e.in_set = (eng_iter[g] >= MAXI - 1);
            sb.push_back(e);
            prev_addr = a;
            rr_m = (g + 1) % N;
            outstanding++;
        end
        if (pix_valid && pix_ready) outstanding--;
    endtask

    // policy 0: acked engine refreshes and keeps requesting
    // policy 1: random requests and random backpressure
    // policy 2: acked engine drops its request
    task automatic step(input int policy, output int g);
        sample_cycle(g);
        @(posedge clk);
        #1;
        case (policy)
            0: if (g >= 0) eng_iter[g] = rand_iter();
            1: begin
                for (int i = 0; i < N; i++) begin
                    if (i == g) begin
                        if ($urandom % 2 == 0) eng_iter[i] = rand_iter();
                        else eng_req[i] = 1'b0;
                    end else if (!eng_req[i] && ($urandom % 3 == 0)) begin
                        eng_req[i]  = 1'b1;
                        eng_iter[i] = rand_iter();
                    end
                end
                pix_ready = ($urandom % 4 != 0);
            end
            default: if (g >= 0) eng_req[g] = 1'b0;
        endcase
    endtask

    task automatic drain();
        int g;
        int n;
        n = 0;
        eng_req   = '0;
        pix_ready = 1'b1;
        while (sb.size() != 0 && n < 40) begin
            step(2, g);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout left=%0d required=0", sb.size());
        end
        check("busy_idle", busy, 0);
    endtask

    // monitor: pops the scoreboard on each accepted pixel, checks hold under backpressure
    exp_t          m_e;
    bit            held = 0;
    logic [RW-1:0] h_rgb;
    logic [IW-1:0] h_eng;
    logic          h_in;
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 0;
        end else if (pix_valid) begin
            if (held) begin
                check("hold_rgb", pix_rgb, h_rgb);
                check("hold_engine", pix_engine, h_eng);
                check("hold_in_set", pix_in_set, h_in);
            end
            if (pix_ready) begin
                held = 0;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pix_unexpected actual=engine%0d required=none", pix_engine);
                end else begin
                    m_e = sb.pop_front();
                    check("pix_rgb", pix_rgb, m_e.rgb);
                    check("pix_engine", pix_engine, m_e.eng);
                    check("pix_in_set", pix_in_set, m_e.in_set);
                end
            end else begin
                held  = 1;
                h_rgb = pix_rgb;
                h_eng = pix_engine;
                h_in  = pix_in_set;
            end
        end else begin
            held = 0;
        end
    end

    logic [DW-1:0] clamp_in [4];
    int            clamp_addr [4];
    bit            clamp_set [4];

    initial begin
        int g;
        int cnt;
        for (int i = 0; i < 64; i++) lut_mem[i] = RW'($urandom);
        eng_req = '0;
        for (int i = 0; i < N; i++) eng_iter[i] = '0;
        pix_ready = 1'b1;
        lut_rgb   = '0;
        clamp_in   = '{32'd49, 32'd50, 32'hFFFF_FFFF, 32'd0};
        clamp_addr = '{49, 49, 49, 0};
        clamp_set  = '{1, 1, 1, 0};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_eng_ack", eng_ack, 0);
        check("rst_lut_rd_en", lut_rd_en, 0);
        check("rst_lut_addr", lut_addr, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_rgb", pix_rgb, 0);
        check("rst_pix_engine", pix_engine, 0);
        check("rst_pix_in_set", pix_in_set, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single request, latency
        eng_req = 4'b0100;
        eng_iter[2] = 32'd7;
        step(2, g);
        check("t1_grant", g, 2);
        step(2, g);
        step(2, g);
        check("t1_valid_T2", last_pv, 0);
        step(2, g);
        check("t1_valid_T3", last_pv, 1);
        drain();

        // sustained throughput
        for (int i = 0; i < N; i++) eng_iter[i] = rand_iter();
        eng_req = '1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, g);
            if (g >= 0) cnt++;
            if (i >= 3) check("thru_pix_each_cycle", last_pv, 1);
        end
        check("thru_grants", cnt, 12);
        drain();

        // round-robin wrap
        eng_req = 4'b0100;
        step(2, g);
        eng_req = 4'b1010;
        step(2, g);
        check("rr_wrap_first", g, 3);
        step(2, g);
        check("rr_wrap_second", g, 1);
        drain();

        // backpressure
        pix_ready = 1'b0;
        eng_req   = '1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, g);
            if (g >= 0) cnt++;
        end
        check("bp_grants", cnt, DEPTH);
        pix_ready = 1'b1;
        for (int i = 0; i < 8; i++) step(0, g);
        drain();

        // clamp boundaries
        for (int k = 0; k < 4; k++) begin
            eng_req     = 4'b0001;
            eng_iter[0] = clamp_in[k];
            step(2, g);
            step(2, g);
            check("clamp_addr", lut_addr, clamp_addr[k]);
            check("clamp_in_set_model", sb[sb.size()-1].in_set, clamp_set[k]);
            drain();
        end

        // reset with two reads in flight and two FIFO entries
        pix_ready = 1'b0;
        eng_req   = '1;
        for (int i = 0; i < 4; i++) step(0, g);
        rst_n   = 1'b0;
        eng_req = '0;
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        outstanding = 0;
        rr_m = 0;
        prev_vld = 0;
        @(negedge clk);
        check("mid_rst_pix_valid", pix_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_eng_ack", eng_ack, 0);
        @(posedge clk);
        #1;
        pix_ready = 1'b1;
        eng_req   = '1;
        step(2, g);
        check("mid_rst_restart", g, 0);
        drain();

        // randomized traffic
        for (int i = 0; i < 400; i++) step(1, g);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pixel_color_scheduler.md
Name: pixel_color_scheduler

Overview:
- Shares one synchronous colour-LUT read port among NUM_ENGINES Mandelbrot iteration engines.
- Round-robin arbitrates completed-pixel requests and clamps each iteration count to a LUT address.
- Tracks the LUT read through a fixed-latency pipeline and buffers results in a small output FIFO.
- Emits an RGB pixel stream with valid/ready handshake toward the frame/video writer.

Parameters:
DATA_WIDTH, 32, width of each engine iteration count
RBG_SIZE, 24, RGB pixel width
MAX_ITERATION, 50, LUT depth; counts >= this map to interior colour
NUM_ENGINES, 30, number of requesting engines
ID_WIDTH, $clog2(NUM_ENGINES), engine index width
ADDR_WIDTH, $clog2(MAX_ITERATION), LUT address width
OUT_DEPTH, 4, output FIFO entries (power of 2, >= 4)

Ports:
clk  in  1  sole clock, rising edge
rst_n  in  1  synchronous, active-low reset
eng_req  in  NUM_ENGINES  per-engine "iteration count ready", held until acked
eng_iter  in  DATA_WIDTH x NUM_ENGINES  unpacked array of iteration counts
eng_ack  out  NUM_ENGINES  one-hot grant, combinational, one cycle
lut_rd_en  out  1  registered LUT read strobe
lut_addr  out  ADDR_WIDTH  registered LUT address
lut_rgb  in  RBG_SIZE  LUT data, valid the cycle after lut_rd_en
pix_valid  out  1  output pixel valid
pix_ready  in  1  downstream accept
pix_rgb  out  RBG_SIZE  pixel colour
pix_engine  out  ID_WIDTH  source engine index
pix_in_set  out  1  1 when source count was >= MAX_ITERATION-1
busy  out  1  any request in flight or FIFO non-empty

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset, sampled at the clk edge with rst_n=0:
  - eng_ack=0, lut_rd_en=0, lut_addr=0.
  - pix_valid=0, pix_rgb=0, pix_engine=0, pix_in_set=0, busy=0.
  - rr_ptr=0, FIFO empty, both pipeline stages invalid.
- Reset mid-operation discards in-flight reads and FIFO contents. No pixel is emitted for them.
- Credit: credit = (fifo_count + s1_valid + s2_valid) < OUT_DEPTH.
  - Uses registered counts only. A pop in the same cycle is not credited.
- Arbitration (combinational, cycle T):
  - If credit and any eng_req, grant k = first requesting index searching rr_ptr, rr_ptr+1, ..., wrapping N-1 -> 0.
  - eng_ack[k]=1 in T only. All other eng_ack bits are 0.
  - No grant without credit.
  - Engines deassert or refresh eng_req on the edge after ack. An engine re-requesting immediately is eligible in T+1 at rr priority.
- rr_ptr update at end of T: rr_ptr <= (k==NUM_ENGINES-1) ? 0 : k+1. Unchanged if no grant.
- Stage 1 (T+1):
  - lut_rd_en=1.
  - lut_addr = (eng_iter[k] >= MAX_ITERATION-1) ? MAX_ITERATION-1 : eng_iter[k][ADDR_WIDTH-1:0].
  - s1 holds k and the in_set flag. Comparison is done at full DATA_WIDTH.
- Stage 2 (T+2): lut_rgb is captured with the s1 tag and written to the FIFO at the end of T+2.
- Output:
  - pix_valid = FIFO non-empty, first possible in T+3. Latency ack to pix_valid = 3 cycles.
  - pix_rgb, pix_engine and pix_in_set are the FIFO head. They hold stable while pix_valid && !pix_ready.
  - Pop on pix_valid && pix_ready.
  - Simultaneous push and pop when full is impossible by credit. Push and pop at any other count keep the count unchanged.
  - Pixels leave in grant order.
- Throughput: with pix_ready held high, one grant per cycle sustained (steady state occupancy 1 + in-flight 2 < 4).
- With pix_ready held low: at most OUT_DEPTH grants are issued, then eng_ack stays 0 until a pop.
- busy = s1_valid | s2_valid | (fifo_count != 0).

Test Plan:
- NUM_ENGINES=4, only eng_req[2] high with iter=7 at T, pix_ready=1 -> eng_ack=4'b0100 at T; lut_rd_en=1, lut_addr=7 at T+1; pix_valid=1 with pix_engine=2, pix_rgb=LUT[7], pix_in_set=0 at T+3.
- All 4 eng_req high continuously, pix_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; pixels emerge in that order, one per cycle, no gaps.
- rr wrap: rr_ptr=3 with requests on engines 1 and 3 -> grant 3, then 1; rr_ptr becomes 0 then 2.
- pix_ready=0, all requests high -> exactly 4 acks, then eng_ack=0; pix_rgb stable. Raise pix_ready -> 4 pixels drain in order and grants resume with one ack per pop.
- Clamp: iter=49, 50, 32'hFFFF_FFFF, 0 -> lut_addr=49, 49, 49, 0; pix_in_set=1, 1, 1, 0.
- rst_n=0 for one cycle with 2 reads in flight and 2 FIFO entries -> the next cycle shows pix_valid=0, busy=0, eng_ack=0. Arbitration restarts from engine 0.
